// File: rtl/cpu_pkg.sv
// Shared encodings, widths and the ID/EX payload for the register-read stage.
package cpu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 4;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [REG_AW-1:0] REG_PC = 4'd15;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  typedef struct packed {
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
  } idex_t;

  // PC read wins over the writeback bypass, which wins over the file read.
  function automatic logic [DATA_W-1:0] sel_operand(
    input logic [REG_AW-1:0] idx,
    input logic [DATA_W-1:0] rf_data,
    input logic [DATA_W-1:0] pc8,
    input logic              we,
    input logic [REG_AW-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    logic [DATA_W-1:0] res;
    res = rf_data;
    if (idx == REG_PC) begin
      res = pc8;
    end else if (we && (wa == idx)) begin
      res = wd;
    end
    return res;
  endfunction

endpackage

// File: rtl/extend.sv
// Combinational immediate extender selected by the instruction class.
module extend
  import cpu_pkg::*;
(
  input  logic [23:0]       imm24,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] imm
);

  always_comb begin
    imm = '0;
    unique case (op)
      OP_DP:   imm = {{(DATA_W-8){1'b0}}, imm24[7:0]};
      OP_MEM:  imm = {{(DATA_W-12){1'b0}}, imm24[11:0]};
      OP_BR:   imm = {{(DATA_W-26){imm24[23]}}, imm24, 2'b00};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/reg_read_stage.sv
// Decode/register-read stage: forms operands and holds them in a one-entry ID/EX register.
module reg_read_stage #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_plus8,
  output logic [3:0]        ra1,
  output logic [3:0]        ra2,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  input  logic              wb_we,
  input  logic [3:0]        wb_wa,
  input  logic [DATA_W-1:0] wb_wd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_op,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_imm,
  output logic [3:0]        out_rd,
  output logic [3:0]        out_src1,
  output logic [3:0]        out_src2
);
  import cpu_pkg::*;

  stage_state_e      state_q, state_d;
  idex_t             idex_q, idex_d;
  logic [1:0]        op;
  logic [DATA_W-1:0] imm_dec;
  logic              capture;

  assign op = instr[27:26];

  // Branches read the PC; stores read the data register from the Rd field.
  always_comb begin
    ra1 = (op == OP_BR) ? REG_PC : instr[19:16];
    ra2 = ((op == OP_MEM) && !instr[20]) ? instr[15:12] : instr[3:0];
  end

  extend u_extend (
    .imm24 (instr[23:0]),
    .op    (op),
    .imm   (imm_dec)
  );

  assign in_ready = (state_q == ST_EMPTY) || out_ready;
  assign capture  = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    idex_d  = idex_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (capture) begin
      state_d     = ST_FULL;
      idex_d.op   = op;
      idex_d.a    = sel_operand(ra1, rd1, pc_plus8, wb_we, wb_wa, wb_wd);
      idex_d.b    = sel_operand(ra2, rd2, pc_plus8, wb_we, wb_wa, wb_wd);
      idex_d.imm  = imm_dec;
      idex_d.rd   = instr[15:12];
      idex_d.src1 = ra1;
      idex_d.src2 = ra2;
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end else if (state_q == ST_FULL) begin
      // Stalled: keep held operands coherent with writebacks landing behind us.
      if (wb_we && (wb_wa == idex_q.src1) && (idex_q.src1 != REG_PC)) begin
        idex_d.a = wb_wd;
      end
      if (wb_we && (wb_wa == idex_q.src2) && (idex_q.src2 != REG_PC)) begin
        idex_d.b = wb_wd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      idex_q  <= '0;
    end else begin
      state_q <= state_d;
      idex_q  <= idex_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_op    = idex_q.op;
  assign out_a     = idex_q.a;
  assign out_b     = idex_q.b;
  assign out_imm   = idex_q.imm;
  assign out_rd    = idex_q.rd;
  assign out_src1  = idex_q.src1;
  assign out_src2  = idex_q.src2;

endmodule
